xmt_fifo: RTL

//   Transmit-side buffer: top writes bytes; block drains them one at a time to
//   the serial XMT_interface via a start/busy handshake.

---
 rtl/xmt_fifo_pkg.sv | 15 +
 rtl/xmt_fifo_sync_fifo.sv | 63 ++++++
 rtl/xmt_fifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/xmt_fifo_pkg.sv
// Shared definitions for the transmit buffer: default widths and FSM encoding.
package xmt_fifo_pkg;

  localparam int unsigned XmtDataW     = 8;
  localparam int unsigned XmtDepthLog2 = 4;

  // Drain FSM encoding; the receive side uses the same 2-bit layout.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } xmt_state_e;

endpackage

// File: rtl/xmt_fifo_sync_fifo.sv
// Synchronous FIFO: storage, natural-wrap pointers, occupancy and flags.
// The caller must not push when full unless it pops in the same cycle.
module xmt_fifo_sync_fifo
  import xmt_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = XmtDataW,
  parameter int unsigned DEPTH_LOG2 = XmtDepthLog2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap modulo depth by overflowing their DEPTH_LOG2 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/xmt_fifo.sv
// Transmit buffer: queues bytes from the command logic and drains them one at
// a time to the serial transmitter with a start/busy handshake.
module xmt_fifo
  import xmt_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = XmtDataW,
  parameter int unsigned DEPTH_LOG2 = XmtDepthLog2,
  parameter int unsigned EDGE_WR    = 1,
  parameter int unsigned BUSY_TO    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  wr_en,
  input  logic                  tx_busy,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_start,
  output logic                  full,
  output logic                  empty_xmt,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_err
);

  localparam int unsigned TimerW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  xmt_state_e          state_q;
  logic [TimerW-1:0]   timer_q;
  logic                wr_en_q;
  logic                push_req;
  logic                push_ok;
  logic                pop;
  logic                empty;
  logic [DATA_W-1:0]   rd_data;

  assign push_req = (EDGE_WR != 0) ? (wr_en & ~wr_en_q) : wr_en;
  // A pop in IDLE frees a slot, so a push into a full FIFO can still land.
  assign pop      = (state_q == StIdle) && !empty;
  assign push_ok  = push_req && (!full || pop);

  xmt_fifo_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_ok),
    .pop     (pop),
    .wr_data (din),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Write edge detect and sticky overflow on a dropped push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_en_q <= wr_en;
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // Drain FSM with registered handshake outputs and busy-timeout tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!empty) begin
            tx_data <= rd_data;
            state_q <= StStart;
          end
        end
        StStart: begin
          tx_start <= 1'b1;
          timer_q  <= '0;
          state_q  <= StWaitBusy;
        end
        StWaitBusy: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end else if (timer_q == TimerW'(BUSY_TO - 1)) begin
            // Failed byte is dropped; draining resumes from IDLE.
            tx_err  <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!tx_busy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign empty_xmt = empty && (state_q == StIdle);

endmodule
